// File: rtl/stage3_fc_seq_ctrl.sv
// stage3_fc_seq_ctrl: stage-3 FC sequencer; streams pooled features into the MAC array,
// fires the bias/output core, then reduces its serialized scores to an argmax class.
module stage3_fc_seq_ctrl #(
    parameter int N_IN    = 48,
    parameter int N_OUT   = 3,
    parameter int VAL_BW  = 24,
    parameter int MAC_LAT = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_mac_clr,
    output logic                       o_feat_rd_en,
    output logic [$clog2(N_IN)-1:0]    o_feat_addr,
    output logic                       o_mac_en,
    output logic                       o_core_valid,
    input  logic                       i_core_valid,
    input  logic [VAL_BW-1:0]          i_core_value,
    input  logic [$clog2(N_OUT)-1:0]   i_core_index,
    output logic                       o_done,
    output logic [$clog2(N_OUT)-1:0]   o_class,
    output logic [VAL_BW-1:0]          o_score,
    output logic                       o_err
);
    localparam int AW = $clog2(N_IN);
    localparam int KW = $clog2(N_OUT);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CLR, FETCH, DRAIN, FIRE, COLLECT, DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [KW-1:0]     k_q, k_d, cls_q, cls_d;
    logic [VAL_BW-1:0] best_q, best_d;
    logic              err_d;
    logic              take;

    assign take = state_q == COLLECT && i_core_valid;

    // cnt_q is shared: DRAIN length in DRAIN, consecutive idle cycles in COLLECT
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        cls_d   = cls_q;
        best_d  = best_q;
        err_d   = o_err;
        case (state_q)
            IDLE: begin
                state_d = i_start ? CLR : IDLE;
                err_d   = i_start ? 1'b0 : o_err;
            end
            CLR: begin
                state_d = FETCH;
                addr_d  = '0;
                cnt_d   = '0;
                k_d     = '0;
                cls_d   = '0;
                best_d  = '0;
            end
            FETCH: begin
                addr_d  = addr_q + 1'b1;
                state_d = addr_q == AW'(N_IN - 1) ? DRAIN : FETCH;
            end
            DRAIN: begin
                cnt_d   = cnt_q == CW'(MAC_LAT) ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == CW'(MAC_LAT) ? FIRE : DRAIN;
            end
            FIRE: state_d = COLLECT;
            COLLECT: begin
                if (take) begin
                    k_d   = k_q + 1'b1;
                    cnt_d = '0;
                    if (k_q == '0 || $signed(i_core_value) > $signed(best_q)) begin
                        best_d = i_core_value;
                        cls_d  = k_q;
                    end
                    err_d   = o_err | (i_core_index != k_q);
                    state_d = k_q == KW'(N_OUT - 1) ? DONE : COLLECT;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    err_d   = o_err | (cnt_q == CW'(TIMEOUT - 1));
                    state_d = cnt_q == CW'(TIMEOUT - 1) ? DONE : COLLECT;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            k_q          <= '0;
            cls_q        <= '0;
            best_q       <= '0;
            o_busy       <= 1'b0;
            o_mac_clr    <= 1'b0;
            o_feat_rd_en <= 1'b0;
            o_feat_addr  <= '0;
            o_mac_en     <= 1'b0;
            o_core_valid <= 1'b0;
            o_done       <= 1'b0;
            o_class      <= '0;
            o_score      <= '0;
            o_err        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            cls_q        <= cls_d;
            best_q       <= best_d;
            o_busy       <= state_d != IDLE;
            o_mac_clr    <= state_d == CLR;
            o_feat_rd_en <= state_d == FETCH;
            o_feat_addr  <= state_d == FETCH ? addr_d : '0;
            o_mac_en     <= o_feat_rd_en;
            o_core_valid <= state_d == FIRE;
            o_done       <= state_d == DONE;
            o_class      <= state_d == DONE ? cls_d : o_class;
            o_score      <= state_d == DONE ? best_d : o_score;
            o_err        <= err_d;
        end
    end
endmodule

// File: tb/tb_stage3_fc_seq_ctrl.sv
// tb_stage3_fc_seq_ctrl: cycle-accurate control checks plus a result scoreboard
// for the stage-3 FC sequencer at default parameters.
module tb_stage3_fc_seq_ctrl;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic        o_busy, o_mac_clr, o_feat_rd_en, o_mac_en, o_core_valid, o_done, o_err;
    logic [5:0]  o_feat_addr;
    logic        i_core_valid = 1'b0;
    logic [23:0] i_core_value = '0;
    logic [1:0]  i_core_index = '0;
    logic [1:0]  o_class;
    logic [23:0] o_score;

    typedef struct {
        logic [1:0]  cls;
        logic [23:0] score;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   failed = 0;

    stage3_fc_seq_ctrl dut (
        .clk(clk), .reset(reset), .i_start(i_start), .o_busy(o_busy),
        .o_mac_clr(o_mac_clr), .o_feat_rd_en(o_feat_rd_en), .o_feat_addr(o_feat_addr),
        .o_mac_en(o_mac_en), .o_core_valid(o_core_valid), .i_core_valid(i_core_valid),
        .i_core_value(i_core_value), .i_core_index(i_core_index), .o_done(o_done),
        .o_class(o_class), .o_score(o_score), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Cycle n counts from the start cycle (n=0). Samples arrive at cycles t0,t1,t2;
    // with respond=0 the core stays silent and the timeout path must end the run.
    task automatic do_run(input logic [23:0] v0, v1, v2, input logic [1:0] x0, x1, x2,
                          input int t0, t1, t2, input bit respond, input bit noise,
                          input logic [1:0] ecls, input logic [23:0] escore, input bit eerr);
        logic [23:0] v[3];
        logic [1:0]  x[3];
        logic [11:0] act, expv;
        exp_t        e;
        int          edone, j;
        bit          got;
        v = '{v0, v1, v2};
        x = '{x0, x1, x2};
        edone = respond ? t2 + 1 : 54 + TIMEOUT;
        exp_q.push_back('{ecls, escore, eerr});
        @(negedge clk);
        compared++;
        if ({o_busy, o_done} !== 2'b00) begin
            failed++;
            $display("FAIL idle_before_start busy/done=%b required 00", {o_busy, o_done});
        end
        i_start = 1'b1;
        got = 1'b0;
        for (int n = 1; n <= edone; n++) begin
            @(negedge clk);
            i_start = noise && n == 30;
            act  = {o_busy, o_mac_clr, o_feat_rd_en, o_feat_addr, o_mac_en, o_core_valid, o_done};
            expv = {1'b1, n == 1, n >= 2 && n <= 49, (n >= 2 && n <= 49) ? 6'(n - 2) : 6'd0,
                    n >= 3 && n <= 50, n == 53, n == edone};
            compared++;
            if (act !== expv) begin
                failed++;
                $display("FAIL ctrl_cycle%0d busy/clr/rd/addr/mac/cv/done=%b required %b", n, act, expv);
            end
            if (n == 1) begin
                compared++;
                if (o_err !== 1'b0) begin
                    failed++;
                    $display("FAIL err_clear_on_start got %b required 0", o_err);
                end
            end
            if (o_done && !got) begin
                got = 1'b1;
                e = exp_q.pop_front();
                compared++;
                if (o_class !== e.cls) begin
                    failed++;
                    $display("FAIL class got %0d required %0d", o_class, e.cls);
                end
                compared++;
                if (o_score !== e.score) begin
                    failed++;
                    $display("FAIL score got %0d required %0d", $signed(o_score), $signed(e.score));
                end
                compared++;
                if (o_err !== e.err) begin
                    failed++;
                    $display("FAIL err got %b required %b", o_err, e.err);
                end
            end
            if (respond && (n == t0 || n == t1 || n == t2)) begin
                j = n == t0 ? 0 : (n == t1 ? 1 : 2);
                i_core_valid = 1'b1;
                i_core_value = v[j];
                i_core_index = x[j];
            end else if (noise && n == 10) begin
                i_core_valid = 1'b1;
                i_core_value = 24'd1000;
                i_core_index = 2'd0;
            end else begin
                i_core_valid = 1'b0;
                i_core_value = 24'($urandom);
                i_core_index = 2'($urandom);
            end
        end
        i_start = 1'b0;
        i_core_valid = 1'b0;
        if (!got) begin
            e = exp_q.pop_front();
            compared++;
            failed++;
            $display("FAIL done_missing got o_done=0 required 1 at cycle %0d", edone);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_start = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({o_busy, o_mac_clr, o_feat_rd_en, o_feat_addr, o_mac_en, o_core_valid, o_done,
             o_class, o_score, o_err} !== '0) begin
            failed++;
            $display("FAIL reset_outputs got nonzero required all 0");
        end
        reset = 1'b0;
        i_start = 1'b0;
        @(negedge clk);
        compared++;
        if (o_busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_release_busy got %b required 0", o_busy);
        end
    endtask

    task automatic test_argmax();
        do_run(24'd5, -24'sd3, 24'd9, 2'd0, 2'd1, 2'd2, 55, 56, 57, 1'b1, 1'b1, 2'd2, 24'd9, 1'b0);
    endtask

    task automatic test_tie_signed();
        do_run(-24'sd7, -24'sd7, -24'sd20, 2'd0, 2'd1, 2'd2, 55, 56, 57, 1'b1, 1'b0,
               2'd0, -24'sd7, 1'b0);
    endtask

    task automatic test_index_err();
        do_run(24'd1, 24'd4, 24'd2, 2'd0, 2'd2, 2'd1, 55, 56, 57, 1'b1, 1'b0, 2'd1, 24'd4, 1'b1);
    endtask

    task automatic test_gaps_err_clear();
        do_run(24'd3, 24'd8, 24'd8, 2'd0, 2'd1, 2'd2, 55, 60, 70, 1'b1, 1'b0, 2'd1, 24'd8, 1'b0);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        i_start = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        compared++;
        if ({o_feat_rd_en, o_feat_addr} !== {1'b1, 6'd20}) begin
            failed++;
            $display("FAIL mid_fetch_addr got rd/addr=%b required %b", {o_feat_rd_en, o_feat_addr}, {1'b1, 6'd20});
        end
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if ({o_busy, o_mac_clr, o_feat_rd_en, o_feat_addr, o_mac_en, o_core_valid, o_done,
             o_class, o_score, o_err} !== '0) begin
            failed++;
            $display("FAIL mid_reset_outputs got nonzero required all 0 (busy=%b rd=%b class=%0d score=%0d)",
                     o_busy, o_feat_rd_en, o_class, o_score);
        end
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if ({o_busy, o_mac_en} !== 2'b00) begin
            failed++;
            $display("FAIL after_reset_idle busy/mac_en=%b required 00", {o_busy, o_mac_en});
        end
    endtask

    task automatic test_timeout();
        do_run(24'd0, 24'd0, 24'd0, 2'd0, 2'd1, 2'd2, 55, 56, 57, 1'b0, 1'b0, 2'd0, 24'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_run(-24'sd1, 24'h7FFFFF, 24'h800000, 2'd0, 2'd1, 2'd2, 55, 56, 57, 1'b1, 1'b0,
               2'd1, 24'h7FFFFF, 1'b0);
    endtask

    initial begin
        test_reset();
        test_argmax();
        test_tie_signed();
        test_index_err();
        test_gaps_err_clear();
        test_mid_reset();
        test_timeout();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
